// File: rtl/median_window_scheduler.sv
// median_window_scheduler: walks frame centers in raster order, issues the 3x3 neighbor addresses, then hands the window to the sorter.
// Define MEDIAN_BORDER_CLAMP_EN to cover the full frame with border-replicated neighbors.
module median_window_scheduler #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int COORD_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      addrReady,
  input  logic                      sortDone,
  output logic signed [COORD_W-1:0] xWindowAddress,
  output logic signed [COORD_W-1:0] yWindowAddress,
  output logic                      addrValid,
  output logic        [COORD_W-1:0] xWindowCenter,
  output logic        [COORD_W-1:0] yWindowCenter,
  output logic                      windowOut,
  output logic                      imageDone,
  output logic                      busy,
  output logic        [1:0]         currentState
);
  typedef enum logic [1:0] {IDLE, FETCH, SORT_WAIT, DONE} state_t;
`ifdef MEDIAN_BORDER_CLAMP_EN
  localparam int X0 = 0, Y0 = 0, XL = IMG_W - 1, YL = IMG_H - 1;
  localparam logic [COORD_W:0] WP = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0] HP = (COORD_W+1)'(IMG_H);
`else
  localparam int X0 = 1, Y0 = 1, XL = IMG_W - 2, YL = IMG_H - 2;
`endif
  localparam logic [COORD_W-1:0] CX0 = COORD_W'(X0);
  localparam logic [COORD_W-1:0] CY0 = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] CXL = COORD_W'(XL);
  localparam logic [COORD_W-1:0] CYL = COORD_W'(YL);
  localparam logic [COORD_W:0]   ONE = (COORD_W+1)'(1);
  state_t             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d, xa_q, xa_d, ya_q, ya_d, nx, ny;
  logic               av_q, av_d, wo_q, wo_d, id_q, id_d;
  logic [1:0]         kx, ky;
  logic [COORD_W:0]   sx, sy;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (abort) begin
      state_d = IDLE;
      k_d     = '0;
      cx_d    = '0;
      cy_d    = '0;
    end else if (state_q == IDLE && start) begin
      state_d = FETCH;
      k_d     = '0;
      cx_d    = CX0;
      cy_d    = CY0;
    end else if (state_q == FETCH && av_q && addrReady) begin
      state_d = (k_q == 4'd8) ? SORT_WAIT : FETCH;
      k_d     = (k_q == 4'd8) ? k_q : k_q + 4'd1;
    end else if (state_q == SORT_WAIT && sortDone) begin
      if (cx_q == CXL && cy_q == CYL) state_d = DONE;
      else begin
        state_d = FETCH;
        k_d     = '0;
        cx_d    = (cx_q == CXL) ? CX0 : cx_q + COORD_W'(1);
        cy_d    = (cx_q == CXL) ? cy_q + COORD_W'(1) : cy_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
      cx_d    = '0;
      cy_d    = '0;
    end
    // Neighbor offset is (k mod 3, k div 3) minus one, folded into the -1 below
    kx = (k_d >= 4'd6) ? 2'(k_d - 4'd6) : (k_d >= 4'd3) ? 2'(k_d - 4'd3) : 2'(k_d);
    ky = (k_d >= 4'd6) ? 2'd2 : (k_d >= 4'd3) ? 2'd1 : 2'd0;
    sx = {1'b0, cx_d} + {{(COORD_W-1){1'b0}}, kx};
    sy = {1'b0, cy_d} + {{(COORD_W-1){1'b0}}, ky};
`ifdef MEDIAN_BORDER_CLAMP_EN
    nx = (sx == '0) ? '0 : (sx > WP) ? CXL : COORD_W'(sx - ONE);
    ny = (sy == '0) ? '0 : (sy > HP) ? CYL : COORD_W'(sy - ONE);
`else
    nx = COORD_W'(sx - ONE);
    ny = COORD_W'(sy - ONE);
`endif
    av_d = state_d == FETCH;
    xa_d = av_d ? nx : '0;
    ya_d = av_d ? ny : '0;
    wo_d = state_q == FETCH && state_d == SORT_WAIT;
    id_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      av_q    <= 1'b0;
      wo_q    <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      av_q    <= av_d;
      wo_q    <= wo_d;
      id_q    <= id_d;
    end
  end
  assign xWindowAddress = $signed(xa_q);
  assign yWindowAddress = $signed(ya_q);
  assign addrValid      = av_q;
  assign xWindowCenter  = cx_q;
  assign yWindowCenter  = cy_q;
  assign windowOut      = wo_q;
  assign imageDone      = id_q;
  assign busy           = state_q != IDLE;
  assign currentState   = state_q;
endmodule
